pea_scheduler: RTL and testbench
================================

PEA_SCHEDULER -- requirements
Module: pea_scheduler

Interface
REQ-001 Parameter FC_TIMEOUT, default 4096: maximum cycles to wait for FC after invoke.
REQ-002 Parameter CNT_W, default 5: output-FIFO occupancy width, log2(32).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begins a run when IDLE, ignored otherwise.
REQ-006 run_count  in  8  instructions to execute; latched on start; 0 = run until halt.
REQ-007 halt  in  1  level; finish the current instruction (including drain), then return to IDLE.
REQ-008 enable  in  1  PEA_enable result for the current next_instr.
REQ-009 FC  in  1  firing-complete level from PEA_top_module_1.
REQ-010 result_pop, status_pop  in  CNT_W each  output-FIFO occupancies.
REQ-011 result_rd_data, status_rd_data  in  32 each  output-FIFO read data, valid the cycle after rd_en.
REQ-012 invoke  out  1  one-cycle firing pulse to the PEA.
REQ-013 next_instr  out  2  PEA mode: SETUP_INSTR=00, INSTR=01, OUTPUT=10.
REQ-014 rd_en_result, rd_en_status  out  1 each  output-FIFO pops, always asserted together.
REQ-015 out_valid  in/out: out  1  host handshake valid; out_ready  in  1  host handshake ready.
REQ-016 out_result, out_status  out  32 each  drained pair presented to the host.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 err  out  1  sticky FC-timeout flag; done_cnt  out  8  instructions completed this run.

Function
REQ-019 States: IDLE, S_CHK, S_FIRE, S_WAIT, I_CHK, I_FIRE, I_WAIT, D_CHK, D_RD, D_CAP, D_OUT, ERR.
REQ-020 IDLE: on start, latch run_count, clear done_cnt and err, go to S_CHK.
REQ-021 next_instr SHALL be SETUP_INSTR in S_*, INSTR in I_*, OUTPUT in D_*, SETUP_INSTR in IDLE/ERR.
REQ-022 next_instr SHALL change only on a state transition and SHALL be stable from *_CHK through *_WAIT.
REQ-023 *_CHK: stay while enable=0; when enable=1, go to *_FIRE.
REQ-024 *_FIRE: assert invoke for exactly one cycle, clear the timeout counter, go to *_WAIT.
REQ-025 *_WAIT: ignore FC in the first WAIT cycle; FC=1 thereafter advances S_WAIT->I_CHK and I_WAIT->D_CHK.
REQ-026 Each WAIT cycle without FC increments the timeout counter; reaching FC_TIMEOUT sets err and enters ERR.
REQ-027 D_CHK: if result_pop!=0 and status_pop!=0, go to D_RD; otherwise finish the instruction.
REQ-028 D_RD: pulse rd_en_result and rd_en_status for one cycle. D_CAP: register both read data into out_result/out_status. D_OUT: out_valid=1 until out_ready=1, then return to D_CHK.
REQ-029 out_result/out_status SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 Finish: increment done_cnt (saturating at 255). If halt=1 or done_cnt+1 equals a nonzero run_count, go to IDLE; else go to S_CHK.
REQ-031 halt SHALL NOT abort a FIRE, WAIT or drain in progress.
REQ-032 ERR: outputs idle and busy=1; leave only on rst or start (start acts as in IDLE).
REQ-033 start while busy SHALL be ignored, with no effect on run_count.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE; invoke, rd_en_*, out_valid, busy, err=0; next_instr=SETUP_INSTR; done_cnt, out_result, out_status, timeout counter=0.
REQ-035 rst mid-run SHALL abandon the run with no invoke or rd_en pulse on the release cycle.

Structure
REQ-036 Package pea_sched_pkg SHALL hold the state enum, the SETUP_INSTR/INSTR/OUTPUT constants and the FC_TIMEOUT default.
REQ-037 The D_* handshake SHALL be sub-module pea_sched_drain; all other logic SHALL reside in pea_scheduler.

Verification
REQ-038 start with run_count=1, enable=1, FC 5 cycles after each invoke, one pair (7,0) queued -> exactly 2 invoke pulses (modes 00 then 01), out (7,0) delivered, done_cnt=1, IDLE.
REQ-039 enable held 0 for 20 cycles in S_CHK -> no invoke and next_instr stays 00; enable=1 -> invoke on the following cycle.
REQ-040 FC never asserted with FC_TIMEOUT=16 -> err=1 and state ERR after 16 WAIT cycles; a subsequent start clears err.
REQ-041 Three pairs queued, out_ready low for 4 cycles per pair -> 3 rd_en pulses, each pair held stable, in FIFO order.
REQ-042 run_count=0 with halt raised during I_WAIT -> current instruction completes and drains, then IDLE with done_cnt incremented by 1.
REQ-043 rst pulsed during I_WAIT -> all outputs at reset values immediately; no invoke after release until start.

Source files
------------

// File: rtl/pea_sched_pkg.sv
// Shared types and constants for the PEA firing scheduler: FSM state encoding,
// PEA instruction-mode codes and the default firing-complete timeout.
package pea_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    S_CHK,
    S_FIRE,
    S_WAIT,
    I_CHK,
    I_FIRE,
    I_WAIT,
    D_CHK,
    D_RD,
    D_CAP,
    D_OUT,
    ERR
  } state_t;

  localparam logic [1:0] SETUP_INSTR = 2'b00;
  localparam logic [1:0] INSTR       = 2'b01;
  localparam logic [1:0] OUTPUT      = 2'b10;

  localparam int FC_TIMEOUT_DEFAULT = 4096;

  // The PEA mode is a pure function of the state, so it can only move on a transition.
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      S_CHK, S_FIRE, S_WAIT:     return SETUP_INSTR;
      I_CHK, I_FIRE, I_WAIT:     return INSTR;
      D_CHK, D_RD, D_CAP, D_OUT: return OUTPUT;
      default:                   return SETUP_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/pea_sched_drain.sv
// Output-FIFO drain handshake: pops one result/status pair, captures it and
// holds it on the host interface until accepted.
module pea_sched_drain
  import pea_sched_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           state_i,
  input  logic [CNT_W-1:0] result_pop_i,
  input  logic [CNT_W-1:0] status_pop_i,
  input  logic [31:0]      result_rd_data_i,
  input  logic [31:0]      status_rd_data_i,
  input  logic             out_ready_i,
  output state_t           next_o,
  output logic             empty_o,
  output logic             rd_en_o,
  output logic             out_valid_o,
  output logic [31:0]      out_result_o,
  output logic [31:0]      out_status_o
);

  logic [31:0] result_q, result_d;
  logic [31:0] status_q, status_d;

  // A pair is only drained when both FIFOs hold data, keeping result and status aligned.
  always_comb begin
    next_o      = state_i;
    empty_o     = (result_pop_i == '0) || (status_pop_i == '0);
    rd_en_o     = 1'b0;
    out_valid_o = 1'b0;
    result_d    = result_q;
    status_d    = status_q;
    case (state_i)
      D_CHK: next_o = empty_o ? D_CHK : D_RD;
      D_RD: begin
        rd_en_o = 1'b1;
        next_o  = D_CAP;
      end
      D_CAP: begin
        result_d = result_rd_data_i;
        status_d = status_rd_data_i;
        next_o   = D_OUT;
      end
      D_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) next_o = D_CHK;
      end
      default: next_o = state_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign out_result_o = result_q;
  assign out_status_o = status_q;

endmodule

// File: rtl/pea_scheduler.sv
// PEA firing scheduler: sequences SETUP_INSTR, INSTR and OUTPUT firings per
// instruction, with FC timeout detection, halt/run-count control and drain.
module pea_scheduler
  import pea_sched_pkg::*;
#(
  parameter int FC_TIMEOUT = FC_TIMEOUT_DEFAULT,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       run_count,
  input  logic             halt,
  input  logic             enable,
  input  logic             FC,
  input  logic [CNT_W-1:0] result_pop,
  input  logic [CNT_W-1:0] status_pop,
  input  logic [31:0]      result_rd_data,
  input  logic [31:0]      status_rd_data,
  input  logic             out_ready,
  output logic             invoke,
  output logic [1:0]       next_instr,
  output logic             rd_en_result,
  output logic             rd_en_status,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic [31:0]      out_status,
  output logic             busy,
  output logic             err,
  output logic [7:0]       done_cnt
);

  localparam int TW = $clog2(FC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FC_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    run_q, run_d;
  logic [7:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  state_t drain_next;
  logic   drain_empty;
  logic   drain_rd_en;

  pea_sched_drain #(
    .CNT_W(CNT_W)
  ) u_drain (
    .clk              (clk),
    .rst              (rst),
    .state_i          (state_q),
    .result_pop_i     (result_pop),
    .status_pop_i     (status_pop),
    .result_rd_data_i (result_rd_data),
    .status_rd_data_i (status_rd_data),
    .out_ready_i      (out_ready),
    .next_o           (drain_next),
    .empty_o          (drain_empty),
    .rd_en_o          (drain_rd_en),
    .out_valid_o      (out_valid),
    .out_result_o     (out_result),
    .out_status_o     (out_status)
  );

  // A zero timeout count marks the first WAIT cycle, where a stale FC level is ignored.
  always_comb begin
    logic finish;
    finish  = 1'b0;
    state_d = state_q;
    run_d   = run_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          run_d   = run_count;
          done_d  = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_CHK;
        end
      end
      S_CHK: if (enable) state_d = S_FIRE;
      I_CHK: if (enable) state_d = I_FIRE;
      S_FIRE, I_FIRE: begin
        tmo_d   = '0;
        state_d = (state_q == S_FIRE) ? S_WAIT : I_WAIT;
      end
      S_WAIT, I_WAIT: begin
        if (FC && (tmo_q != '0)) begin
          state_d = (state_q == S_WAIT) ? I_CHK : D_CHK;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      D_CHK: begin
        if (drain_empty) finish = 1'b1;
        else             state_d = drain_next;
      end
      D_RD, D_CAP, D_OUT: state_d = drain_next;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      done_d = (done_q == 8'hFF) ? done_q : done_q + 8'd1;
      if (halt || ((run_q != 8'd0) && (({1'b0, done_q} + 9'd1) == {1'b0, run_q})))
        state_d = IDLE;
      else
        state_d = S_CHK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign invoke       = (state_q == S_FIRE) || (state_q == I_FIRE);
  assign next_instr   = mode_of(state_q);
  assign rd_en_result = drain_rd_en;
  assign rd_en_status = drain_rd_en;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign done_cnt     = done_q;

endmodule

// File: tb/tb_pea_scheduler.sv
// Self-checking bench for pea_scheduler: PEA/FC and output-FIFO models plus a
// scoreboard of expected drained pairs compared against host-side deliveries.
module tb_pea_scheduler;

  localparam int CNT_W    = 5;
  localparam int FC_TMO   = 16;
  localparam int FC_DELAY = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       run_count = 8'd0;
  logic             halt = 1'b0;
  logic             enable = 1'b0;
  logic             fc = 1'b0;
  logic [CNT_W-1:0] result_pop = '0;
  logic [CNT_W-1:0] status_pop = '0;
  logic [31:0]      result_rd_data = '0;
  logic [31:0]      status_rd_data = '0;
  logic             out_ready = 1'b0;
  logic             invoke;
  logic [1:0]       next_instr;
  logic             rd_en_result, rd_en_status;
  logic             out_valid;
  logic [31:0]      out_result, out_status;
  logic             busy, err;
  logic [7:0]       done_cnt;

  int checks = 0;
  int failures = 0;

  logic [63:0] fifo_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [1:0]  inv_modes[$];
  int inv_cnt = 0, rd_cnt = 0, stall_cnt = 0, stab_viol = 0, rd_pair_bad = 0;
  int vcnt = 0, ready_delay = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pres = '0, psta = '0;
  bit fc_enable = 1'b1;
  int fc_cnt = 0;

  pea_scheduler #(
    .FC_TIMEOUT(FC_TMO),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .run_count      (run_count),
    .halt           (halt),
    .enable         (enable),
    .FC             (fc),
    .result_pop     (result_pop),
    .status_pop     (status_pop),
    .result_rd_data (result_rd_data),
    .status_rd_data (status_rd_data),
    .out_ready      (out_ready),
    .invoke         (invoke),
    .next_instr     (next_instr),
    .rd_en_result   (rd_en_result),
    .rd_en_status   (rd_en_status),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_status     (out_status),
    .busy           (busy),
    .err            (err),
    .done_cnt       (done_cnt)
  );

  always #5 clk = ~clk;

  // Output FIFO pair: read data appears the cycle after the pop.
  always @(posedge clk) begin : fifo_model
    logic [63:0] pair;
    if (rd_en_result && fifo_q.size() > 0) begin
      pair = fifo_q.pop_front();
      result_rd_data <= pair[63:32];
      status_rd_data <= pair[31:0];
    end
    result_pop <= CNT_W'(fifo_q.size());
    status_pop <= CNT_W'(fifo_q.size());
  end

  // PEA model: FC rises FC_DELAY cycles after each invoke and stays high until the next one.
  always @(posedge clk) begin
    if (invoke) begin
      fc_cnt <= 0;
      fc     <= 1'b0;
    end else begin
      if (fc_cnt < 255) fc_cnt <= fc_cnt + 1;
      fc <= fc_enable && (fc_cnt + 1 >= FC_DELAY);
    end
  end

  task automatic tick();
    if (out_valid) begin
      out_ready = (vcnt >= ready_delay);
      vcnt++;
    end else begin
      out_ready = 1'b0;
      vcnt = 0;
    end
    if (invoke) begin
      inv_cnt++;
      inv_modes.push_back(next_instr);
    end
    if (rd_en_result) rd_cnt++;
    if (rd_en_result !== rd_en_status) rd_pair_bad++;
    if (out_valid && out_ready) obs_q.push_back({out_result, out_status});
    if (out_valid && !out_ready) stall_cnt++;
    if (out_valid && pv && !pr && ((out_result !== pres) || (out_status !== psta))) stab_viol++;
    pv = out_valid;
    pr = out_ready;
    pres = out_result;
    psta = out_status;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    inv_cnt = 0; rd_cnt = 0; stall_cnt = 0; stab_viol = 0; rd_pair_bad = 0;
    inv_modes.delete();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_pair(input logic [31:0] r, input logic [31:0] s);
    fifo_q.push_back({r, s});
    exp_q.push_back({r, s});
  endtask

  task automatic do_start(input logic [7:0] rc);
    run_count = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_count = ~rc;
  endtask

  task automatic wait_idle(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (invoke !== 1'b0) begin failures++; $display("[TB] FAIL reset_invoke: got %b expected 0", invoke); end
    checks++; if (next_instr !== 2'b00) begin failures++; $display("[TB] FAIL reset_mode: got %b expected 00", next_instr); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_done: got %0d expected 0", done_cnt); end
    checks++; if ({out_valid, rd_en_result, rd_en_status} !== 3'b000) begin failures++; $display("[TB] FAIL reset_hs: got %b expected 000", {out_valid, rd_en_result, rd_en_status}); end
    checks++; if ({out_result, out_status} !== 64'd0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", {out_result, out_status}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_run();
    bit to;
    logic [63:0] got, want;
    clear_log();
    enable = 1'b1; fc_enable = 1'b1; ready_delay = 0;
    push_pair(32'd7, 32'd0);
    do_start(8'd1);
    wait_idle(300, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL single_idle: timed out=%b expected 0", to); end
    checks++; if (inv_cnt != 2) begin failures++; $display("[TB] FAIL single_invokes: got %0d expected 2", inv_cnt); end
    checks++;
    if (inv_modes.size() != 2 || inv_modes[0] !== 2'b00 || inv_modes[1] !== 2'b01) begin
      failures++; $display("[TB] FAIL single_modes: got %0d invokes expected modes 00,01", inv_modes.size());
    end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++; $display("[TB] FAIL single_out_count: got %0d expected 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("[TB] FAIL single_out_pair: got %h expected %h", got, want); end
    end
    checks++; if (done_cnt !== 8'd1) begin failures++; $display("[TB] FAIL single_done: got %0d expected 1", done_cnt); end
    checks++; if (rd_cnt != 1) begin failures++; $display("[TB] FAIL single_rd: got %0d expected 1", rd_cnt); end
  endtask

  task automatic test_enable_gate();
    bit to;
    bit bad_mode;
    clear_log();
    enable = 1'b0; bad_mode = 1'b0;
    do_start(8'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin run_count = 8'd5; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (next_instr !== 2'b00) bad_mode = 1'b1;
    end
    start = 1'b0;
    checks++; if (inv_cnt != 0) begin failures++; $display("[TB] FAIL gate_no_invoke: got %0d expected 0", inv_cnt); end
    checks++; if (bad_mode !== 1'b0) begin failures++; $display("[TB] FAIL gate_mode: mode change seen=%b expected 0", bad_mode); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL gate_busy: got %b expected 1", busy); end
    enable = 1'b1;
    tick();
    checks++; if ({invoke, next_instr} !== 3'b100) begin failures++; $display("[TB] FAIL gate_invoke: got %b expected 100", {invoke, next_instr}); end
    wait_idle(300, to);
    checks++; if (to !== 1'b0 || done_cnt !== 8'd1) begin failures++; $display("[TB] FAIL gate_done: timeout=%b done=%0d expected 0/1", to, done_cnt); end
  endtask

  task automatic test_timeout();
    bit to;
    int n;
    clear_log();
    fc_enable = 1'b0; enable = 1'b1; n = -1;
    do_start(8'd1);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (invoke && n < 0) n = 0;
      else if (n >= 0) n++;
      if (err) break;
    end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err: got %b expected 1", err); end
    checks++; if (n != FC_TMO + 1) begin failures++; $display("[TB] FAIL tmo_cycles: got %0d expected %0d", n, FC_TMO + 1); end
    checks++; if ({busy, invoke, next_instr, out_valid} !== 5'b10000) begin failures++; $display("[TB] FAIL tmo_outputs: got %b expected 10000", {busy, invoke, next_instr, out_valid}); end
    repeat (5) tick();
    checks++; if ({err, busy} !== 2'b11) begin failures++; $display("[TB] FAIL tmo_sticky: got %b expected 11", {err, busy}); end
    fc_enable = 1'b1;
    do_start(8'd1);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_clear: got %b expected 0", err); end
    wait_idle(300, to);
    checks++; if (to !== 1'b0 || done_cnt !== 8'd1 || err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_rerun: timeout=%b done=%0d err=%b expected 0/1/0", to, done_cnt, err); end
  endtask

  task automatic test_drain();
    bit to;
    logic [63:0] got, want;
    clear_log();
    fc_enable = 1'b1; enable = 1'b1; ready_delay = 4;
    for (int k = 0; k < 3; k++) push_pair($urandom, $urandom);
    do_start(8'd1);
    wait_idle(500, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL drain_idle: timed out=%b expected 0", to); end
    checks++; if (rd_cnt != 3) begin failures++; $display("[TB] FAIL drain_rd: got %0d expected 3", rd_cnt); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        failures++; $display("[TB] FAIL drain_pair%0d: got %0d left expected %0d", k, obs_q.size(), exp_q.size());
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin failures++; $display("[TB] FAIL drain_pair%0d: got %h expected %h", k, got, want); end
      end
    end
    checks++; if (stall_cnt != 12) begin failures++; $display("[TB] FAIL drain_stalls: got %0d expected 12", stall_cnt); end
    checks++; if (stab_viol != 0) begin failures++; $display("[TB] FAIL drain_stable: got %0d changes expected 0", stab_viol); end
    checks++; if (rd_pair_bad != 0) begin failures++; $display("[TB] FAIL drain_rd_pair: got %0d splits expected 0", rd_pair_bad); end
    ready_delay = 0;
  endtask

  task automatic test_halt();
    bit to, found;
    logic [63:0] got, want;
    clear_log();
    found = 1'b0;
    push_pair(32'hA5A5_0001, 32'h5A5A_0002);
    do_start(8'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (invoke && next_instr == 2'b01) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL halt_reach: got %b expected 1", found); end
    tick();
    tick();
    halt = 1'b1;
    wait_idle(300, to);
    halt = 1'b0;
    checks++; if (to !== 1'b0 || done_cnt !== 8'd1) begin failures++; $display("[TB] FAIL halt_done: timeout=%b done=%0d expected 0/1", to, done_cnt); end
    checks++; if (inv_cnt != 2) begin failures++; $display("[TB] FAIL halt_invokes: got %0d expected 2", inv_cnt); end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++; $display("[TB] FAIL halt_drain: got %0d pairs expected 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("[TB] FAIL halt_drain: got %h expected %h", got, want); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    clear_log();
    found = 1'b0;
    enable = 1'b1;
    do_start(8'd0);
    for (int i = 0; i < 200 && done_cnt !== 8'd1; i++) tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (invoke && next_instr == 2'b01 && done_cnt == 8'd1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_reach: got %b expected 1", found); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, invoke, next_instr, rd_en_result, rd_en_status, out_valid, err} !== 8'd0 || done_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_async: got flags=%b done=%0d expected 0/0",
               {busy, invoke, next_instr, rd_en_result, rd_en_status, out_valid, err}, done_cnt);
    end
    tick();
    rst = 1'b0;
    clear_log();
    repeat (20) tick();
    checks++; if (inv_cnt != 0 || rd_cnt != 0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_quiet: invokes=%0d rd=%0d busy=%b expected 0/0/0", inv_cnt, rd_cnt, busy); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_enable_gate();
    test_timeout();
    test_drain();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
